// File: rtl/reset_sequencer.sv
// Ordered reset release for the MITM datapath: all stages assert together, then release
// bit 0 first, STAGE_DELAY cycles apart. Optional macro RESET_SEQ_SOFT_RST_EN lets soft_rst_req act as rst_sig.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_POR     | after configuration, counting POR_CYCLES before first release
// ST_HOLD    | reset source active, all stages held in reset
// ST_RELEASE | releasing stages one at a time, STAGE_DELAY cycles apart
// ST_DONE    | all stages released, seq_done high
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int POR_CYCLES  = 32
) (
  input  logic                  sys_clk,
  input  logic                  rst_sig,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_out,
  output logic                  seq_done
);

  localparam int MAX_CNT = (STAGE_DELAY > POR_CYCLES) ? STAGE_DELAY : POR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Power-up values come from device configuration; there is no reset before rst_sig.
  state_t                  state_q     = ST_POR;
  logic [CNT_W-1:0]        cnt_q       = '0;
  logic [IDX_W-1:0]        idx_q       = '0;
  logic [NUM_STAGES-1:0]   stage_rst_q = '1;
  logic                    seq_done_q  = 1'b0;

  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_d;
  logic [IDX_W-1:0]        idx_d;
  logic [NUM_STAGES-1:0]   stage_rst_d;
  logic                    seq_done_d;
  logic                    rst_eff;

`ifdef RESET_SEQ_SOFT_RST_EN
  assign rst_eff = rst_sig | soft_rst_req;
`else
  logic unused_soft_rst;
  assign unused_soft_rst = soft_rst_req;
  assign rst_eff         = rst_sig;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    seq_done_d  = seq_done_q;
    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
        idx_d   = '0;
      end
      ST_RELEASE: begin
        if (cnt_q == DLY_LAST) begin
          // Shifting in a zero clears bit idx_q, which keeps release strictly in order.
          stage_rst_d = stage_rst_q << 1;
          idx_d       = idx_q + 1'b1;
          cnt_d       = '0;
          if (idx_q == IDX_LAST) begin
            seq_done_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst_eff) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign stage_rst_out = stage_rst_q;
  assign seq_done      = seq_done_q;

endmodule
